ahbl_to_apb: RTL and testbench
==============================

Name: ahbl_to_apb

Overview:
- AHB-Lite responder that terminates one crossbar slave port (dst_* side) and converts each accepted transfer into a single APB3 transfer.
- Lets low-bandwidth peripherals (UART, GPIO, timers) hang off a crossbar slave port.
- One APB transfer is outstanding at a time. The AHB data phase is stretched with hready_resp until the APB transfer completes.

Parameters:
- W_ADDR, 32, AHB address width.
- W_DATA, 32, AHB and APB data width.
- W_PADDR, 16, APB address width; paddr = haddr[W_PADDR-1:0].

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ahbls_hready  input  1  bus HREADY (previous data phase complete)
- ahbls_hready_resp  output  1  this slave's HREADYOUT
- ahbls_hresp  output  1  1 = ERROR response
- ahbls_haddr  input  W_ADDR  address phase address
- ahbls_hwrite  input  1  address phase direction
- ahbls_htrans  input  2  transfer type
- ahbls_hsize  input  3  accepted, ignored
- ahbls_hburst  input  3  accepted, ignored
- ahbls_hprot  input  4  accepted, ignored
- ahbls_hmastlock  input  1  accepted, ignored
- ahbls_hwdata  input  W_DATA  write data, valid in first data-phase cycle
- ahbls_hrdata  output  W_DATA  read data
- apbm_paddr  output  W_PADDR  APB address
- apbm_psel  output  1  APB select
- apbm_penable  output  1  APB enable
- apbm_pwrite  output  1  APB direction
- apbm_pwdata  output  W_DATA  APB write data
- apbm_prdata  input  W_DATA  APB read data
- apbm_pready  input  1  APB ready
- apbm_pslverr  input  1  APB slave error

Behaviour:
- Reset is asynchronous, active-low, and may occur mid-operation. It forces:
  - state = READY
  - hready_resp = 1, hresp = 0, hrdata = 0
  - psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0
  - No APB transfer survives reset.
- All outputs are registered or decoded from state. There is no combinational path from APB inputs to AHB outputs.
- States: READY, WDATA, SETUP, ACCESS, ERR0, ERR1.
- Accept condition: hready & htrans[1] (NONSEQ or SEQ).
  - Evaluated only in READY and ERR1, the two states where hready_resp = 1.
  - On accept: latch paddr = haddr[W_PADDR-1:0] and pwrite = hwrite.
  - Write accepted -> WDATA. Read accepted -> SETUP.
  - IDLE/BUSY, or hready = 0 -> go to / stay in READY.
- WDATA: hready_resp = 0; latch pwdata = hwdata; go to SETUP.
- SETUP: psel = 1, penable = 0, hready_resp = 0; go to ACCESS.
- ACCESS: psel = 1, penable = 1, hready_resp = 0.
  - Hold while pready = 0; no timeout.
  - pready & !pslverr -> READY. If read, register hrdata = prdata on the same edge.
  - pready & pslverr -> ERR0.
  - psel and penable drop to 0 on the edge leaving ACCESS.
- ERR0: hready_resp = 0, hresp = 1; go to ERR1.
- ERR1: hready_resp = 1, hresp = 1.
  - A new accept is allowed here (pipelined; the master may instead drive IDLE).
  - Otherwise -> READY.
- hresp = 0 in every state except ERR0 and ERR1.
- hrdata holds its last value until the next successful read. Writes and errors do not change it.
- Latency, counting cycles after the address-phase edge with zero-wait APB:
  - Read: SETUP, ACCESS, READY = 3 cycles, of which 2 are wait states.
  - Write: WDATA, SETUP, ACCESS, READY = 4 cycles, of which 3 are wait states.
  - Each APB wait cycle adds 1.
  - An error adds 1 over success (ERR0 + ERR1 replaces READY).
- Back-to-back: a transfer accepted in the completing READY cycle enters SETUP/WDATA next cycle, so psel stays low for at least one cycle between transfers.
- No write strobes: all sizes are forwarded as full-word, with pwdata = hwdata unmodified.

Test Plan:
- Read 0x4000_0123, zero-wait APB, prdata = 0xDEADBEEF -> paddr = 0x0123, SETUP then ACCESS; hready_resp low for 2 cycles; hrdata = 0xDEADBEEF with hready_resp = 1, hresp = 0.
- Write 0x4000_0040, hwdata = 0x12345678, pready low for 3 ACCESS cycles -> pwrite = 1, pwdata = 0x12345678 stable from SETUP; penable high 4 cycles; hready_resp low 6 cycles.
- Read with pslverr = 1 -> ERR0 (hready_resp = 0, hresp = 1), then ERR1 (hready_resp = 1, hresp = 1), then READY with hresp = 0; hrdata unchanged.
- Back-to-back write 0x10 then read 0x14, second presented in completing cycle -> second accepted without extra idle cycle; psel low exactly 1 cycle (WDATA-free read path: SETUP next).
- htrans = BUSY/IDLE and hready = 0 with htrans = NONSEQ in READY -> no psel, hready_resp stays 1.
- rst_n asserted during ACCESS with pready = 0 -> psel and penable drop immediately (async), hready_resp = 1, state READY; the next read completes normally.

Source files
------------

// File: rtl/ahbl_to_apb_if.sv
// AHB-Lite slave port plus APB3 master port bundled for the bridge.
// slave modport: bridge side; master modport: system/peripheral side.
interface ahbl_to_apb_if #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_PADDR = 16
);
  logic              ahbls_hready;
  logic              ahbls_hready_resp;
  logic              ahbls_hresp;
  logic [W_ADDR-1:0] ahbls_haddr;
  logic              ahbls_hwrite;
  logic [1:0]        ahbls_htrans;
  logic [2:0]        ahbls_hsize;
  logic [2:0]        ahbls_hburst;
  logic [3:0]        ahbls_hprot;
  logic              ahbls_hmastlock;
  logic [W_DATA-1:0] ahbls_hwdata;
  logic [W_DATA-1:0] ahbls_hrdata;

  logic [W_PADDR-1:0] apbm_paddr;
  logic               apbm_psel;
  logic               apbm_penable;
  logic               apbm_pwrite;
  logic [W_DATA-1:0]  apbm_pwdata;
  logic [W_DATA-1:0]  apbm_prdata;
  logic               apbm_pready;
  logic               apbm_pslverr;

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite,
    input  ahbls_htrans, ahbls_hsize, ahbls_hburst,
    input  ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    output apbm_paddr, apbm_psel, apbm_penable,
    output apbm_pwrite, apbm_pwdata,
    input  apbm_prdata, apbm_pready, apbm_pslverr
  );

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite,
    output ahbls_htrans, ahbls_hsize, ahbls_hburst,
    output ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    input  apbm_paddr, apbm_psel, apbm_penable,
    input  apbm_pwrite, apbm_pwdata,
    output apbm_prdata, apbm_pready, apbm_pslverr
  );
endinterface

// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave to APB3 bridge, one APB transfer outstanding at a time.
// Ports: clk, rst_n (async, active-low), bus (ahbl_to_apb_if.slave).
module ahbl_to_apb #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_PADDR = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ahbl_to_apb_if.slave       bus
);

  typedef enum logic [2:0] {
    READY,
    WDATA,
    SETUP,
    ACCESS,
    ERR0,
    ERR1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W_PADDR-1:0] paddr_q;
  logic               pwrite_q;
  logic [W_DATA-1:0]  pwdata_q;
  logic [W_DATA-1:0]  hrdata_q;

  logic open_st;
  logic accept;
  logic done;

  logic hready_resp;
  logic hresp;
  logic psel;
  logic penable;

  // Only READY and ERR1 drive hready_resp high, so only they see
  // a valid address phase.
  assign open_st = (state_q == READY) || (state_q == ERR1);
  assign accept  = open_st & bus.ahbls_hready
                 & bus.ahbls_htrans[1];
  assign done    = (state_q == ACCESS) & bus.apbm_pready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      READY, ERR1: begin
        if (accept) begin
          state_d = bus.ahbls_hwrite ? WDATA : SETUP;
        end else begin
          state_d = READY;
        end
      end
      WDATA:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (bus.apbm_pready) begin
          state_d = bus.apbm_pslverr ? ERR0 : READY;
        end
      end
      ERR0:    state_d = ERR1;
      default: state_d = READY;
    endcase
  end

  always_comb begin
    hready_resp = 1'b0;
    hresp       = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    unique case (1'b1)
      (state_q == READY): hready_resp = 1'b1;
      (state_q == SETUP): psel = 1'b1;
      (state_q == ACCESS): begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      (state_q == ERR0): hresp = 1'b1;
      (state_q == ERR1): begin
        hready_resp = 1'b1;
        hresp       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= bus.ahbls_haddr[W_PADDR-1:0];
        pwrite_q <= bus.ahbls_hwrite;
      end
      if (state_q == WDATA) begin
        pwdata_q <= bus.ahbls_hwdata;
      end
      if (done && !bus.apbm_pslverr && !pwrite_q) begin
        hrdata_q <= bus.apbm_prdata;
      end
    end
  end

  assign bus.ahbls_hready_resp = hready_resp;
  assign bus.ahbls_hresp       = hresp;
  assign bus.ahbls_hrdata      = hrdata_q;
  assign bus.apbm_paddr        = paddr_q;
  assign bus.apbm_psel         = psel;
  assign bus.apbm_penable      = penable;
  assign bus.apbm_pwrite       = pwrite_q;
  assign bus.apbm_pwdata       = pwdata_q;

  // Sideband AHB fields carry no meaning for a full-word APB bridge.
  logic unused;
  assign unused = ^{bus.ahbls_hsize, bus.ahbls_hburst,
                    bus.ahbls_hprot, bus.ahbls_hmastlock,
                    bus.ahbls_htrans[0],
                    bus.ahbls_haddr[W_ADDR-1:W_PADDR]};

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Bench for ahbl_to_apb: vector table, APB scoreboard, corner sequences.
// No ports; drives the bridge through an ahbl_to_apb_if instance.
module tb_ahbl_to_apb;

  logic clk;
  logic rst_n;

  ahbl_to_apb_if #(.W_ADDR(32), .W_DATA(32), .W_PADDR(16)) bus ();

  ahbl_to_apb #(.W_ADDR(32), .W_DATA(32), .W_PADDR(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // APB peripheral model
  int          apb_waits = 0;
  bit          apb_err   = 1'b0;
  logic [31:0] apb_rdata = '0;
  int          acc_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (bus.apbm_psel && bus.apbm_penable && !bus.apbm_pready)
      acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign bus.apbm_pready  = bus.apbm_psel & bus.apbm_penable
                          & (acc_cnt == apb_waits);
  assign bus.apbm_pslverr = apb_err & bus.apbm_pready;
  assign bus.apbm_prdata  = apb_rdata;

  // APB-side scoreboard
  typedef struct {
    logic [15:0] paddr;
    bit          wr;
    logic [31:0] wdata;
    int          nen;
  } apb_t;

  apb_t        sbq[$];
  int          pen_cnt;
  logic [15:0] snap_addr;
  logic [31:0] snap_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      pen_cnt = 0;
    end else begin
      if (bus.apbm_psel && !bus.apbm_penable) begin
        snap_addr  = bus.apbm_paddr;
        snap_wdata = bus.apbm_pwdata;
      end
      if (bus.apbm_psel && bus.apbm_penable) begin
        pen_cnt++;
        if (bus.apbm_pready) begin
          if (sbq.size() == 0) begin
            chk("apb unexpected transfer", 32'd1, 32'd0);
          end else begin
            apb_t e;
            e = sbq.pop_front();
            chk("apb paddr", 32'(bus.apbm_paddr), 32'(e.paddr));
            chk("apb paddr setup", 32'(snap_addr), 32'(e.paddr));
            chk("apb pwrite", 32'(bus.apbm_pwrite), 32'(e.wr));
            if (e.wr) begin
              chk("apb pwdata", bus.apbm_pwdata, e.wdata);
              chk("apb pwdata setup", snap_wdata, e.wdata);
            end
            chk("apb penable cycles", 32'(pen_cnt), 32'(e.nen));
          end
          pen_cnt = 0;
        end
      end
    end
  end

  // AHB master helpers
  task automatic start(bit wr, logic [31:0] addr, logic [31:0] wd);
    apb_t e;
    bus.ahbls_htrans = 2'b10;
    bus.ahbls_haddr  = addr;
    bus.ahbls_hwrite = wr;
    bus.ahbls_hready = 1'b1;
    e.paddr = addr[15:0];
    e.wr    = wr;
    e.wdata = wd;
    e.nen   = apb_waits + 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.ahbls_htrans = 2'b00;
    bus.ahbls_hwrite = 1'b0;
    bus.ahbls_hwdata = wd;
  endtask

  task automatic finish(string nm, int exp_low, bit exp_err,
                        logic [31:0] exp_rd);
    int   cnt = 0;
    logic last_hresp = 1'b0;
    while (bus.ahbls_hready_resp !== 1'b1 && cnt < 64) begin
      last_hresp = bus.ahbls_hresp;
      cnt++;
      @(posedge clk); #1;
    end
    chk({nm, " wait cycles"}, 32'(cnt), 32'(exp_low));
    chk({nm, " hresp last wait"}, 32'(last_hresp), 32'(exp_err));
    chk({nm, " hresp"}, 32'(bus.ahbls_hresp), 32'(exp_err));
    chk({nm, " hrdata"}, bus.ahbls_hrdata, exp_rd);
    if (exp_err) begin
      @(posedge clk); #1;
      chk({nm, " hresp after err"}, 32'(bus.ahbls_hresp), 32'd0);
      chk({nm, " ready after err"},
          32'(bus.ahbls_hready_resp), 32'd1);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    bit          err;
    int          exp_low;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h4000_0123, 32'h0, 32'hDEAD_BEEF,
                0, 1'b0, 2, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h4000_0040, 32'h1234_5678, 32'h0,
                3, 1'b0, 6, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D,
                0, 1'b1, 3, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h1234_5678, 32'h0, 32'hA5A5_5A5A,
                1, 1'b0, 3, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 32'h0,
                0, 1'b1, 4, 32'hA5A5_5A5A};
    vecs[5] = '{1'b0, 32'h8000_0004, 32'h0, 32'h0000_0001,
                2, 1'b0, 4, 32'h0000_0001};

    rst_n               = 1'b0;
    bus.ahbls_hready    = 1'b1;
    bus.ahbls_haddr     = '0;
    bus.ahbls_hwrite    = 1'b0;
    bus.ahbls_htrans    = 2'b00;
    bus.ahbls_hsize     = 3'b010;
    bus.ahbls_hburst    = 3'b000;
    bus.ahbls_hprot     = 4'b0011;
    bus.ahbls_hmastlock = 1'b0;
    bus.ahbls_hwdata    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst hready_resp", 32'(bus.ahbls_hready_resp), 32'd1);
    chk("rst hresp", 32'(bus.ahbls_hresp), 32'd0);
    chk("rst hrdata", bus.ahbls_hrdata, 32'd0);
    chk("rst psel", 32'(bus.apbm_psel), 32'd0);
    chk("rst penable", 32'(bus.apbm_penable), 32'd0);
    chk("rst pwrite", 32'(bus.apbm_pwrite), 32'd0);
    chk("rst paddr", 32'(bus.apbm_paddr), 32'd0);
    chk("rst pwdata", bus.apbm_pwdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      apb_waits = vecs[i].waits;
      apb_err   = vecs[i].err;
      apb_rdata = vecs[i].prdata;
      start(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      finish($sformatf("vec%0d", i), vecs[i].exp_low,
             vecs[i].err, vecs[i].exp_rd);
      @(posedge clk); #1;
    end

    // back-to-back: read issued in the write's completing cycle
    apb_waits = 0;
    apb_err   = 1'b0;
    start(1'b1, 32'h0000_0010, 32'hAABB_CCDD);
    finish("b2b write", 3, 1'b0, 32'h0000_0001);
    chk("b2b gap psel", 32'(bus.apbm_psel), 32'd0);
    apb_rdata = 32'h0BAD_F00D;
    start(1'b0, 32'h0000_0014, 32'h0);
    chk("b2b setup psel", 32'(bus.apbm_psel), 32'd1);
    chk("b2b setup penable", 32'(bus.apbm_penable), 32'd0);
    finish("b2b read", 2, 1'b0, 32'h0BAD_F00D);

    // BUSY and stalled NONSEQ must not start anything
    bus.ahbls_haddr  = 32'h4000_0100;
    bus.ahbls_htrans = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("busy psel", 32'(bus.apbm_psel), 32'd0);
      chk("busy ready", 32'(bus.ahbls_hready_resp), 32'd1);
    end
    bus.ahbls_htrans = 2'b10;
    bus.ahbls_hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hready0 psel", 32'(bus.apbm_psel), 32'd0);
      chk("hready0 ready", 32'(bus.ahbls_hready_resp), 32'd1);
    end
    bus.ahbls_htrans = 2'b00;
    bus.ahbls_hready = 1'b1;
    @(posedge clk); #1;
    chk("idle psel", 32'(bus.apbm_psel), 32'd0);

    // reset while stuck in ACCESS
    apb_waits = 1000;
    start(1'b0, 32'h4000_0300, 32'h0);
    begin
      int n = 0;
      while (bus.apbm_penable !== 1'b1 && n < 10) begin
        n++;
        @(posedge clk); #1;
      end
      chk("reach access", 32'(bus.apbm_penable), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("arst psel", 32'(bus.apbm_psel), 32'd0);
    chk("arst penable", 32'(bus.apbm_penable), 32'd0);
    chk("arst ready", 32'(bus.ahbls_hready_resp), 32'd1);
    chk("arst hresp", 32'(bus.ahbls_hresp), 32'd0);
    chk("arst hrdata", bus.ahbls_hrdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apb_waits = 0;
    apb_rdata = 32'h55AA_1234;
    @(posedge clk); #1;
    start(1'b0, 32'h4000_0008, 32'h0);
    finish("post rst read", 2, 1'b0, 32'h55AA_1234);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
